// File: rtl/hqm_rcfwl_gclk_mesh_seq.sv
`default_nettype none
// ============================================================================
// Module   : hqm_rcfwl_gclk_mesh_seq
// Brief    : Staggered on/off sequencer for global-clock mesh partition gates,
//            aligned to pll_sync after lock, with emergency shutdown on lock loss.
// Revision : 1.0 - initial release
// ============================================================================
module hqm_rcfwl_gclk_mesh_seq #(
    parameter int NUM_PART     = 4,
    parameter int STAGGER      = 8,
    parameter int SYNC_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_req,
    input  logic                pll_lock,
    input  logic                pll_sync_in,
    input  logic                err_clr,
    output logic [NUM_PART-1:0] part_en,
    output logic                mesh_ready,
    output logic                sync_err,
    output logic                lock_lost,
    output logic [2:0]          seq_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_WAIT_SYNC = 3'd2;
    localparam logic [2:0] S_RAMP_UP   = 3'd3;
    localparam logic [2:0] S_ON        = 3'd4;
    localparam logic [2:0] S_RAMP_DOWN = 3'd5;

    localparam logic [7:0]          C_STEP_LAST = 8'(STAGGER - 1);
    localparam logic [15:0]         C_TMO_LAST  = 16'(SYNC_TIMEOUT - 1);
    localparam logic [NUM_PART-1:0] C_ALL_ON    = '1;
    localparam logic [NUM_PART-1:0] C_ONE       = NUM_PART'(1);

    logic [2:0]          r_state;
    logic [NUM_PART-1:0] r_part_en;
    logic                r_mesh_ready;
    logic                r_sync_err;
    logic                r_lock_lost;
    logic [7:0]          r_step;
    logic [15:0]         r_timer;

    logic                w_active;
    logic                w_lock_drop;
    logic                w_tmo;
    logic                w_step_wrap;
    logic [NUM_PART-1:0] w_pe_up;
    logic [NUM_PART-1:0] w_pe_dn;

    assign w_active    = (r_state == S_RAMP_UP) || (r_state == S_ON) || (r_state == S_RAMP_DOWN);
    assign w_lock_drop = w_active && !pll_lock;
    // A sync arriving on the timeout cycle wins, so the timeout only fires when nothing else moves the FSM.
    assign w_tmo       = (r_state == S_WAIT_SYNC) && enable_req && pll_lock && !pll_sync_in &&
                         (r_timer == C_TMO_LAST);
    assign w_step_wrap = (r_step == C_STEP_LAST);
    assign w_pe_up     = {r_part_en[NUM_PART-2:0], 1'b1};
    assign w_pe_dn     = {1'b0, r_part_en[NUM_PART-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_part_en    <= '0;
            r_mesh_ready <= 1'b0;
            r_sync_err   <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_step       <= '0;
            r_timer      <= '0;
        end else begin
            if (w_tmo)
                r_sync_err <= 1'b1;
            else if (err_clr)
                r_sync_err <= 1'b0;

            if (w_lock_drop)
                r_lock_lost <= 1'b1;
            else if (err_clr)
                r_lock_lost <= 1'b0;

            if (w_lock_drop) begin
                r_part_en    <= '0;
                r_mesh_ready <= 1'b0;
                r_step       <= '0;
                r_timer      <= '0;
                r_state      <= enable_req ? S_WAIT_LOCK : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (enable_req)
                            r_state <= S_WAIT_LOCK;
                    end
                    S_WAIT_LOCK: begin
                        if (!enable_req) begin
                            r_state <= S_IDLE;
                        end else if (pll_lock) begin
                            r_state <= S_WAIT_SYNC;
                            r_timer <= '0;
                        end
                    end
                    S_WAIT_SYNC: begin
                        if (!enable_req) begin
                            r_state <= S_IDLE;
                        end else if (!pll_lock) begin
                            r_state <= S_WAIT_LOCK;
                        end else if (pll_sync_in) begin
                            r_state   <= S_RAMP_UP;
                            r_part_en <= C_ONE;
                            r_step    <= '0;
                        end else if (w_tmo) begin
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end
                    S_RAMP_UP: begin
                        if (!enable_req) begin
                            r_part_en <= w_pe_dn;
                            r_step    <= '0;
                            r_state   <= (w_pe_dn == '0) ? S_IDLE : S_RAMP_DOWN;
                        end else if (r_part_en == C_ALL_ON) begin
                            r_state      <= S_ON;
                            r_mesh_ready <= 1'b1;
                        end else if (w_step_wrap) begin
                            r_part_en <= w_pe_up;
                            r_step    <= '0;
                        end else begin
                            r_step <= r_step + 8'd1;
                        end
                    end
                    S_ON: begin
                        if (!enable_req) begin
                            r_state      <= S_RAMP_DOWN;
                            r_mesh_ready <= 1'b0;
                            r_part_en    <= w_pe_dn;
                            r_step       <= '0;
                        end
                    end
                    S_RAMP_DOWN: begin
                        // enable_req is deliberately ignored here; a restart must go back through IDLE.
                        if (w_step_wrap) begin
                            r_part_en <= w_pe_dn;
                            r_step    <= '0;
                            if (w_pe_dn == '0)
                                r_state <= S_IDLE;
                        end else begin
                            r_step <= r_step + 8'd1;
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_part_en    <= '0;
                        r_mesh_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign part_en    = r_part_en;
    assign mesh_ready = r_mesh_ready;
    assign sync_err   = r_sync_err;
    assign lock_lost  = r_lock_lost;
    assign seq_state  = r_state;

    a_part_en_thermo: assert property (@(posedge clk) disable iff (rst)
        ((r_part_en & (r_part_en + C_ONE)) == '0));
    a_ready_all_on: assert property (@(posedge clk) disable iff (rst)
        (!r_mesh_ready || (r_part_en == C_ALL_ON)));

endmodule
`default_nettype wire

// File: tb/tb_hqm_rcfwl_gclk_mesh_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hqm_rcfwl_gclk_mesh_seq
// Brief    : Directed scenarios plus random traffic against a partition-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hqm_rcfwl_gclk_mesh_seq;

    localparam int NP = 4;
    localparam int ST = 8;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst, enable_req, pll_lock, pll_sync_in, err_clr;
    logic [NP-1:0] part_en;
    logic          mesh_ready, sync_err, lock_lost;
    logic [2:0]    seq_state;

    int vectors     = 0;
    int miscompares = 0;

    // Model: phase number (0..5), count of lit partitions, stagger/timer counts, flags
    int m_state, m_lit, m_cnt, m_tmr;
    bit m_ready, m_serr, m_llost;

    always #5 clk = ~clk;

    hqm_rcfwl_gclk_mesh_seq #(.NUM_PART(NP), .STAGGER(ST), .SYNC_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable_req(enable_req), .pll_lock(pll_lock),
        .pll_sync_in(pll_sync_in), .err_clr(err_clr), .part_en(part_en),
        .mesh_ready(mesh_ready), .sync_err(sync_err), .lock_lost(lock_lost),
        .seq_state(seq_state)
    );

    function automatic void model_step();
        bit set_se, set_ll;
        set_se = 0;
        set_ll = 0;
        if (rst) begin
            m_state = 0; m_lit = 0; m_cnt = 0; m_tmr = 0;
            m_ready = 0; m_serr = 0; m_llost = 0;
            return;
        end
        if (m_state >= 3 && !pll_lock) begin
            set_ll = 1; m_lit = 0; m_ready = 0; m_cnt = 0;
            m_state = enable_req ? 1 : 0;
        end else begin
            case (m_state)
                0: if (enable_req) m_state = 1;
                1: if (!enable_req) m_state = 0;
                   else if (pll_lock) begin m_state = 2; m_tmr = 0; end
                2: if (!enable_req) m_state = 0;
                   else if (!pll_lock) m_state = 1;
                   else if (pll_sync_in) begin m_state = 3; m_lit = 1; m_cnt = 0; end
                   else if (m_tmr == TO - 1) begin set_se = 1; m_tmr = 0; end
                   else m_tmr++;
                3: if (!enable_req) begin
                       m_lit--; m_cnt = 0;
                       m_state = (m_lit == 0) ? 0 : 5;
                   end else if (m_lit == NP) begin m_state = 4; m_ready = 1; end
                   else if (m_cnt == ST - 1) begin m_lit++; m_cnt = 0; end
                   else m_cnt++;
                4: if (!enable_req) begin m_state = 5; m_ready = 0; m_lit--; m_cnt = 0; end
                5: if (m_cnt == ST - 1) begin
                       m_lit--; m_cnt = 0;
                       if (m_lit == 0) m_state = 0;
                   end else m_cnt++;
                default: m_state = 0;
            endcase
        end
        if (set_se) m_serr = 1; else if (err_clr) m_serr = 0;
        if (set_ll) m_llost = 1; else if (err_clr) m_llost = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("part_en",    part_en,    (1 << m_lit) - 1);
        chk("mesh_ready", mesh_ready, m_ready);
        chk("sync_err",   sync_err,   m_serr);
        chk("lock_lost",  lock_lost,  m_llost);
        chk("seq_state",  seq_state,  m_state);
    endtask

    task automatic sync_pulse();
        pll_sync_in = 1'b1;
        cycle();
        pll_sync_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable_req = 1'b0; pll_lock = 1'b0; pll_sync_in = 1'b0; err_clr = 1'b0;
        m_state = 0; m_lit = 0; m_cnt = 0; m_tmr = 0; m_ready = 0; m_serr = 0; m_llost = 0;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (5) cycle();
        chk("reset_state", seq_state, 3'd0);

        // Basic ramp-up
        enable_req = 1'b1; pll_lock = 1'b1;
        repeat (2) cycle();
        chk("enter_wait_sync", seq_state, 3'd2);
        repeat (3) cycle();
        sync_pulse();
        chk("up_0001", part_en, 4'b0001);
        for (int k = 2; k <= 26; k++) begin
            cycle();
            if (k == 9)  chk("up_0011", part_en, 4'b0011);
            if (k == 17) chk("up_0111", part_en, 4'b0111);
            if (k == 25) chk("up_1111", part_en, 4'b1111);
            if (k == 26) begin
                chk("up_ready", mesh_ready, 1'b1);
                chk("up_on", seq_state, 3'd4);
            end
        end

        // Ramp-down
        enable_req = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            cycle();
            if (k == 1) begin
                chk("dn_ready", mesh_ready, 1'b0);
                chk("dn_0111", part_en, 4'b0111);
            end
            if (k == 9)  chk("dn_0011", part_en, 4'b0011);
            if (k == 17) chk("dn_0001", part_en, 4'b0001);
            if (k == 25) begin
                chk("dn_0000", part_en, 4'b0000);
                chk("dn_idle", seq_state, 3'd0);
            end
        end

        // Sync timeout
        enable_req = 1'b1;
        repeat (2) cycle();
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 19) chk("tmo_early", sync_err, 1'b0);
        end
        chk("tmo_set", sync_err, 1'b1);
        chk("tmo_state", seq_state, 3'd2);
        sync_pulse();
        chk("tmo_ramp", seq_state, 3'd3);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("tmo_clr", sync_err, 1'b0);
        repeat (30) cycle();
        chk("tmo_on", seq_state, 3'd4);

        // Lock loss in ON
        pll_lock = 1'b0;
        cycle();
        chk("ll_part_en", part_en, 4'b0000);
        chk("ll_ready", mesh_ready, 1'b0);
        chk("ll_flag", lock_lost, 1'b1);
        chk("ll_state", seq_state, 3'd1);
        pll_lock = 1'b1;
        cycle();
        sync_pulse();
        repeat (26) cycle();
        chk("ll_reramp", seq_state, 3'd4);

        // Abort mid-ramp
        enable_req = 1'b0;
        repeat (25) cycle();
        enable_req = 1'b1;
        repeat (2) cycle();
        sync_pulse();
        repeat (8) cycle();
        chk("ab_0011", part_en, 4'b0011);
        enable_req = 1'b0;
        cycle();
        chk("ab_0001", part_en, 4'b0001);
        enable_req = 1'b1;
        for (int j = 2; j <= 10; j++) begin
            cycle();
            if (j == 8) chk("ab_hold", seq_state, 3'd5);
            if (j == 9) begin
                chk("ab_0000", part_en, 4'b0000);
                chk("ab_idle", seq_state, 3'd0);
            end
        end
        chk("ab_restart", seq_state, 3'd1);

        // Reset mid-ramp with sticky flags set
        cycle();
        repeat (20) cycle();
        chk("rs_serr_set", sync_err, 1'b1);
        sync_pulse();
        repeat (16) cycle();
        chk("rs_0111", part_en, 4'b0111);
        rst = 1'b1;
        cycle();
        chk("rs_part_en", part_en, 4'b0000);
        chk("rs_serr", sync_err, 1'b0);
        chk("rs_llost", lock_lost, 1'b0);
        chk("rs_state", seq_state, 3'd0);
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) enable_req = ~enable_req;
            if (pll_lock) pll_lock = ($urandom_range(0, 59) != 0);
            else          pll_lock = ($urandom_range(0, 5) == 0);
            pll_sync_in = ($urandom_range(0, 29) == 0);
            err_clr     = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
